// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] ADD3_THRESH = 4'd5;
    localparam logic [DIGIT_W-1:0] ADD3_VAL    = 4'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between a requester and the binary-to-BCD converter.
interface bin_to_bcd_seq_if
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);

    logic                        start;
    logic [BIN_W-1:0]            bin_in;
    logic                        busy;
    logic                        done;
    logic [DIGIT_W*DIGITS-1:0]   bcd_out;

    modport master (output start, bin_in, input busy, done, bcd_out);
    modport slave  (input start, bin_in, output busy, done, bcd_out);

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 (mod 16) to a BCD digit that is 5 or more.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] digit_o
);

    assign digit_o = (digit_i >= ADD3_THRESH) ? digit_i + ADD3_VAL : digit_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, result registered on the last shift.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
)(
    input  logic             clk,
    input  logic             rst_n,
    bin_to_bcd_seq_if.slave  bus
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int TOT_W = BCD_W + BIN_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    if (longint'(10) ** DIGITS <= longint'(2) ** BIN_W) begin : g_bad_digits
        $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
    end

    state_t             state_q;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   work_q, work_d, work_adj;
    logic [CNT_W-1:0]   cnt_q;
    logic [BCD_W-1:0]   bcd_q;
    logic               busy_q;
    logic               done_q;
    logic [TOT_W-1:0]   shifted;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (work_q[g*DIGIT_W +: DIGIT_W]),
            .digit_o (work_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Correct first, then shift: the binary MSB enters the BCD LSB.
    assign shifted = {work_adj, shift_q} << 1;
    assign work_d  = shifted[TOT_W-1 -: BCD_W];
    assign shift_d = shifted[BIN_W-1:0];

    // NOTE: every register here is a flop with a known reset value; non-blocking
    // assignments keep all state updates referencing pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        shift_q <= bus.bin_in;
                        work_q  <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_q <= shift_d;
                    work_q  <= work_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        bcd_q   <= work_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.bcd_out = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: cycle model of busy/done, queue of expected BCD results.
module tb_bin_to_bcd_seq;

    localparam int BIN_W  = 8;
    localparam int DIGITS = 3;
    localparam int BCD_W  = 4 * DIGITS;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_bad  = 0;
    int n_exp  = 0;
    int n_done = 0;
    int cyc    = 0;
    int prev_done_cyc = 0;
    int last_done_cyc = 0;

    logic [BCD_W-1:0] sb[$];
    logic [BCD_W-1:0] last_exp;
    int               phase;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [BCD_W-1:0] ref_bcd(input int v);
        logic [BCD_W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Cycle model: phase 0 = idle, 1..BIN_W = shifting, BIN_W+1 = done cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 0;
            sb.delete();
        end else if (phase == 0) begin
            if (bus.start === 1'b1) begin
                phase <= 1;
                sb.push_back(ref_bcd(int'(bus.bin_in)));
            end
        end else begin
            phase <= (phase == BIN_W + 1) ? 0 : phase + 1;
        end
    end

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_exp = '0;
        end else begin
            check("busy", 32'(bus.busy), 32'(phase != 0));
            check("done", 32'(bus.done), 32'(phase == BIN_W + 1));
            if (bus.done === 1'b1) begin
                n_done++;
                prev_done_cyc = last_done_cyc;
                last_done_cyc = cyc;
                if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
                else last_exp = sb.pop_front();
            end
            check("bcd_out", 32'(bus.bcd_out), 32'(last_exp));
            for (int d = 0; d < DIGITS; d++)
                check("digit_range", 32'(bus.bcd_out[4*d +: 4] <= 4'd9), 32'd1);
        end
    end

    task automatic wait_dones(input int target);
        int k;
        for (k = 0; k < 40; k++) begin
            @(posedge clk);
            if (n_done >= target) break;
        end
        if (k == 40) check("timeout", 32'(n_done), 32'(target));
    endtask

    task automatic convert(input int v);
        @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.bin_in = 8'(v);
        n_exp++;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_dones(n_exp);
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.bin_in = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_bcd",  32'(bus.bcd_out), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        convert(0);
        convert(255);
        convert(200);
        convert(9);

        // Start pulse and bin_in changes during SHIFT must be ignored.
        @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.bin_in = 8'd13;
        n_exp++;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.bin_in = 8'd99;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.bin_in = 8'd77;
        wait_dones(n_exp);
        repeat (15) @(posedge clk);
        check("no_extra_done", 32'(n_done), 32'(n_exp));

        // Reset in the 4th SHIFT cycle of a 170 conversion.
        @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.bin_in = 8'd170;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_bcd",  32'(bus.bcd_out), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_no_done", 32'(n_done), 32'(n_exp));
        convert(170);

        // Back-to-back with start held high.
        @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.bin_in = 8'd47;
        n_exp += 2;
        @(posedge clk);
        #1;
        bus.bin_in = 8'd128;
        repeat (BIN_W + 2) @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_dones(n_exp);
        check("b2b_spacing", 32'(last_done_cyc - prev_done_cyc), 32'(BIN_W + 2));

        for (int v = 0; v < 256; v++) convert(v);

        repeat (4) @(posedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("done_count", 32'(n_done), 32'(n_exp));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 The block SHALL have parameter BIN_W, default 8: binary input width.
REQ-002 The block SHALL have parameter DIGITS, default 3: BCD digit count; 10^DIGITS > 2^BIN_W is required, checked at elaboration.
REQ-003 The block SHALL have ports:
- clk  in  1: single clock, rising edge.
- rst_n  in  1: reset, asynchronous, active-low.
- start  in  1: conversion request, sampled only in IDLE.
- bin_in  in  BIN_W: unsigned value, captured when start is accepted.
- busy  out  1: conversion in progress.
- done  out  1: one-cycle result-valid pulse.
- bcd_out  out  4*DIGITS: packed BCD, digit 0 in [3:0].

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-005 In IDLE, start=1 SHALL, on that edge:
- load bin_in into a shift register;
- clear the BCD working register;
- clear the iteration counter;
- go to SHIFT.
REQ-006 In IDLE, start=0 SHALL leave all state unchanged.
REQ-007 Each SHIFT cycle SHALL:
- add 3 to every working digit >= 5;
- then shift {working BCD, shift register} left one bit, inserting the binary MSB into the BCD LSB.
REQ-008 SHIFT SHALL last exactly BIN_W cycles, counted by a counter of width clog2(BIN_W+1).
REQ-009 On the BIN_W-th shift edge the block SHALL register the final working value into bcd_out and go to DONE.
REQ-010 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-011 Latency: with start accepted at edge T0, done SHALL be high in the cycle after edge T0+BIN_W; the next start SHALL be accepted no earlier than edge T0+BIN_W+2.
REQ-012 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE.
REQ-013 done SHALL be 1 only in DONE.
REQ-014 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-015 bin_in changes after acceptance SHALL NOT affect the result.
REQ-016 bcd_out SHALL hold its last result until the next conversion's DONE edge.
REQ-017 bcd_out SHALL NOT show intermediate values.
REQ-018 With start held at 1 continuously, conversions SHALL repeat back-to-back every BIN_W+2 cycles.
REQ-019 Every digit of bcd_out SHALL always be in the range 0..9.
REQ-020 The digit add-3 correction SHALL be 4-bit modulo arithmetic and SHALL apply only when the digit is >= 5.
REQ-021 All outputs SHALL be registered.

Reset
REQ-022 rst_n=0 SHALL immediately force, regardless of clk:
- state = IDLE;
- busy = 0, done = 0;
- bcd_out = 0;
- shift register, working register and counter = 0.
REQ-023 Reset asserted mid-conversion SHALL abort the conversion, SHALL NOT produce a done pulse, and SHALL NOT update bcd_out.
REQ-024 After rst_n deasserts, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Structure
REQ-025 Package bcd_pkg SHALL contain:
- the FSM state enum (IDLE/SHIFT/DONE);
- the ADD3_THRESH=5 and ADD3_VAL=3 constants;
- the BCD digit width constant 4.
REQ-026 Combinational sub-module bcd_digit_adj (4-bit in, 4-bit out, add-3 if >= 5) SHALL be instantiated DIGITS times.
REQ-027 The FSM, counter and registers SHALL reside in bin_to_bcd_seq.

Verification
REQ-028 Reset, start=1, bin_in=0: done pulse in the 9th cycle after the accept edge -> bcd_out=12'h000; busy high for exactly 9 cycles.
REQ-029 bin_in=8'd255 -> bcd_out=12'h255.
REQ-030 bin_in=8'd200 -> 12'h200; the next conversion with bin_in=8'd9 -> 12'h009.
REQ-031 Convert 8'd13, pulse start with bin_in=8'd99 during SHIFT, and change bin_in to 8'd77 -> result 12'h013; exactly one done pulse; no second conversion.
REQ-032 Assert rst_n=0 at the 4th SHIFT cycle of an 8'd170 conversion -> immediate busy=0 and bcd_out=0; no done pulse; a following 8'd170 conversion -> 12'h170.
REQ-033 Hold start=1 with bin_in stepping 8'd47 then 8'd128 -> done pulses 10 cycles apart, with results 12'h047 then 12'h128.
REQ-034 Exhaustive 0..255 sweep: bcd_out SHALL match the reference decimal value, with all digits <= 9.
